imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter.sv | 111 +++++++++++
 tb/tb_imem_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - instruction memory arbiter between fetch and debug/loader with halt handshake
module imem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    input  logic        d_halt_req,
    output logic        d_halt_ack,
    output logic [31:0] m_addr,
    output logic        m_we,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rd_data
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [3:0]  starve_cnt;
    logic [31:0] m_addr_q;

    // Grant selection: fetch first in RUN unless debug has starved; only debug outside RUN
    always_comb begin
        f_gnt = 1'b0;
        d_gnt = 1'b0;
        if (rst_n) begin
            case (state)
                ST_RUN: begin
                    if (d_req && (!f_req || starve_cnt == LIMIT)) begin
                        d_gnt = 1'b1;
                    end else begin
                        f_gnt = f_req;
                    end
                end
                default: d_gnt = d_req;
            endcase
        end
    end

    // Halt state machine; a fetch granted in the last RUN cycle returns during DRAIN,
    // so DRAIN never needs more than one cycle
    always_comb begin
        state_nxt = ST_RUN;
        case (state)
            ST_RUN:    state_nxt = d_halt_req ? ST_DRAIN : ST_RUN;
            ST_DRAIN:  state_nxt = d_halt_req ? ST_HALTED : ST_RUN;
            ST_HALTED: state_nxt = d_halt_req ? ST_HALTED : ST_RUN;
            default:   state_nxt = ST_RUN;
        endcase
    end

    // Memory port follows the granted requester; address holds its last granted value when idle
    always_comb begin
        m_addr  = m_addr_q;
        m_wdata = '0;
        if (f_gnt) begin
            m_addr = f_addr;
        end else if (d_gnt) begin
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end
        m_we = d_gnt & d_we;
    end

    assign f_rdata = m_rd_data;
    assign d_rdata = m_rd_data;

    // Registered state, starvation counter, read-valid pipeline and halt acknowledge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            starve_cnt <= 4'd0;
            f_rvalid   <= 1'b0;
            d_rvalid   <= 1'b0;
            d_halt_ack <= 1'b0;
            m_addr_q   <= 32'd0;
        end else begin
            state      <= state_nxt;
            f_rvalid   <= f_gnt;
            d_rvalid   <= d_gnt & ~d_we;
            d_halt_ack <= (state_nxt == ST_HALTED);
            m_addr_q   <= m_addr;
            if (state != ST_RUN && state_nxt == ST_RUN) begin
                starve_cnt <= 4'd0;
            end else if (d_req && !d_gnt) begin
                if (starve_cnt != LIMIT) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else begin
                starve_cnt <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - directed self-checking bench with reference model for imem_arbiter
module tb_imem_arbiter;

    localparam int LIM = 4;

    logic        clk;
    logic        rst_n;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_gnt;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_halt_req;
    logic        d_halt_ack;
    logic [31:0] m_addr;
    logic        m_we;
    logic [31:0] m_wdata;
    logic [31:0] m_rd_data;

    int checks = 0;
    int errors = 0;

    imem_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .d_halt_req(d_halt_req), .d_halt_ack(d_halt_ack),
        .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_rd_data(m_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: registers the address, data appears the following cycle
    logic [31:0] mem    [0:1023];
    logic [31:0] shadow [0:1023];

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]    = 32'h1000_0000 | 32'(i);
            shadow[i] = 32'h1000_0000 | 32'(i);
        end
    end

    always @(posedge clk) begin
        if (m_we) mem[m_addr[11:2]] <= m_wdata;
        m_rd_data <= mem[m_addr[11:2]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=running, 1=draining, 2=halted
    int          md_mode = 0;
    int          md_starve = 0;
    bit          md_f_pend = 0;
    bit          md_d_pend = 0;
    logic [31:0] md_rdata = '0;
    logic [31:0] md_last = '0;

    always @(negedge clk) begin
        bit          eg_f, eg_d, e_we;
        logic [31:0] e_addr;
        int          nmode;
        if (!rst_n) begin
            md_mode = 0; md_starve = 0; md_f_pend = 0; md_d_pend = 0; md_last = '0;
            chk("m_rst_fgnt", {31'd0, f_gnt}, 32'd0);
            chk("m_rst_dgnt", {31'd0, d_gnt}, 32'd0);
            chk("m_rst_mwe", {31'd0, m_we}, 32'd0);
            chk("m_rst_frv", {31'd0, f_rvalid}, 32'd0);
            chk("m_rst_drv", {31'd0, d_rvalid}, 32'd0);
            chk("m_rst_ack", {31'd0, d_halt_ack}, 32'd0);
            chk("m_rst_maddr", m_addr, 32'd0);
        end else begin
            eg_f = 0; eg_d = 0;
            if (md_mode == 0) begin
                if (d_req && (!f_req || md_starve >= LIM)) eg_d = 1;
                else eg_f = f_req;
            end else begin
                eg_d = d_req;
            end
            e_addr = eg_f ? f_addr : (eg_d ? d_addr : md_last);
            e_we   = eg_d && d_we;
            chk("m_fgnt", {31'd0, f_gnt}, {31'd0, eg_f});
            chk("m_dgnt", {31'd0, d_gnt}, {31'd0, eg_d});
            chk("m_maddr", m_addr, e_addr);
            chk("m_mwe", {31'd0, m_we}, {31'd0, e_we});
            if (e_we) chk("m_mwdata", m_wdata, d_wdata);
            chk("m_ack", {31'd0, d_halt_ack}, {31'd0, md_mode == 2});
            chk("m_frv", {31'd0, f_rvalid}, {31'd0, md_f_pend});
            chk("m_drv", {31'd0, d_rvalid}, {31'd0, md_d_pend});
            if (md_f_pend) chk("m_frdata", f_rdata, md_rdata);
            if (md_d_pend) chk("m_drdata", d_rdata, md_rdata);
            md_f_pend = eg_f;
            md_d_pend = eg_d && !d_we;
            md_rdata  = shadow[e_addr[11:2]];
            if (e_we) shadow[e_addr[11:2]] = d_wdata;
            md_last = e_addr;
            if (d_req && !eg_d) md_starve = (md_starve + 1 > LIM) ? LIM : md_starve + 1;
            else md_starve = 0;
            if (!d_halt_req) nmode = 0;
            else nmode = (md_mode == 0) ? 1 : 2;
            if (nmode == 0 && md_mode != 0) md_starve = 0;
            md_mode = nmode;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_halt_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_fgnt", {31'd0, f_gnt}, 32'd0);
        chk("rst_ack", {31'd0, d_halt_ack}, 32'd0);
        chk("rst_maddr", m_addr, 32'd0);
        next_cycle();
        rst_n = 1'b1;

        // single fetch
        f_req = 1'b1; f_addr = 32'h0000_0010;
        @(negedge clk);
        chk("fetch_gnt", {31'd0, f_gnt}, 32'd1);
        chk("fetch_maddr", m_addr, 32'h10);
        next_cycle();
        f_req = 1'b0;
        @(negedge clk);
        chk("fetch_rvalid", {31'd0, f_rvalid}, 32'd1);
        chk("fetch_rdata", f_rdata, 32'h1000_0004);

        // starvation: debug wins on the fifth contended cycle
        next_cycle();
        f_req = 1'b1; f_addr = 32'h40; d_req = 1'b1; d_addr = 32'h20;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i < 5) begin
                chk("starve_deny", {31'd0, d_gnt}, 32'd0);
                chk("starve_fgnt", {31'd0, f_gnt}, 32'd1);
            end else begin
                chk("starve_dgnt", {31'd0, d_gnt}, 32'd1);
                chk("starve_fblk", {31'd0, f_gnt}, 32'd0);
            end
            next_cycle();
        end
        d_req = 1'b0;
        @(negedge clk);
        chk("starve_drv", {31'd0, d_rvalid}, 32'd1);
        chk("starve_drdata", d_rdata, 32'h1000_0008);

        // debug alone is granted immediately
        next_cycle();
        f_req = 1'b0; d_req = 1'b1; d_addr = 32'h24;
        @(negedge clk);
        chk("dbg_gnt", {31'd0, d_gnt}, 32'd1);
        next_cycle();
        d_req = 1'b0;
        @(negedge clk);
        chk("dbg_rdata", d_rdata, 32'h1000_0009);
        next_cycle();
        @(negedge clk);
        chk("idle_maddr_hold", m_addr, 32'h24);

        // halt handshake
        next_cycle();
        f_req = 1'b1; f_addr = 32'h30; d_halt_req = 1'b1;
        @(negedge clk);
        chk("halt_fgnt_n", {31'd0, f_gnt}, 32'd1);
        next_cycle();
        @(negedge clk);
        chk("halt_frv_n1", {31'd0, f_rvalid}, 32'd1);
        chk("halt_frdata", f_rdata, 32'h1000_000C);
        chk("halt_nofetch_n1", {31'd0, f_gnt}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("halt_ack_n2", {31'd0, d_halt_ack}, 32'd1);
        chk("halt_nofetch_n2", {31'd0, f_gnt}, 32'd0);

        // debug write while halted, then read it back
        next_cycle();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("wr_mwe", {31'd0, m_we}, 32'd1);
        chk("wr_dgnt", {31'd0, d_gnt}, 32'd1);
        next_cycle();
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        chk("wr_no_rvalid", {31'd0, d_rvalid}, 32'd0);
        chk("wr_mwe_once", {31'd0, m_we}, 32'd0);
        next_cycle();
        d_req = 1'b1; d_addr = 32'h100;
        @(negedge clk);
        chk("rd_dgnt", {31'd0, d_gnt}, 32'd1);
        next_cycle();
        d_req = 1'b0;
        @(negedge clk);
        chk("rd_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("rd_rdata", d_rdata, 32'hDEAD_BEEF);

        // release halt: fetch resumes the following cycle
        next_cycle();
        d_halt_req = 1'b0;
        @(negedge clk);
        chk("rel_ack_still", {31'd0, d_halt_ack}, 32'd1);
        chk("rel_nofetch", {31'd0, f_gnt}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("rel_ack_off", {31'd0, d_halt_ack}, 32'd0);
        chk("rel_fgnt", {31'd0, f_gnt}, 32'd1);

        // reset in the middle of a granted read
        next_cycle();
        f_addr = 32'h14;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_fgnt", {31'd0, f_gnt}, 32'd0);
        chk("mid_rst_maddr", m_addr, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("mid_rst_frv", {31'd0, f_rvalid}, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_fgnt", {31'd0, f_gnt}, 32'd1);
        chk("post_rst_maddr", m_addr, 32'h14);
        next_cycle();
        f_req = 1'b0;
        @(negedge clk);
        chk("post_rst_rdata", f_rdata, 32'h1000_0005);
        repeat (3) next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
